// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus saturating direction counters, optionally gshare-indexed.
// Predicts next-PC in Fetch; trains and detects mispredicts in Execute.
module branch_predictor #(
   parameter int WIDTH    = 32,
   parameter int ENTRIES  = 16,
   parameter int CTR_BITS = 2,
   parameter int GHR_BITS = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] PC_F,
   output logic             pred_taken_F,
   output logic [WIDTH-1:0] pred_target_F,
   input  logic             update_E,
   input  logic [WIDTH-1:0] PC_E,
   input  logic             is_branch_E,
   input  logic             is_jump_E,
   input  logic             taken_E,
   input  logic [WIDTH-1:0] target_E,
   input  logic             pred_taken_E,
   input  logic [WIDTH-1:0] pred_target_E,
   output logic             mispredict_E,
   output logic [WIDTH-1:0] redirect_E
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = WIDTH - IDX - 2;
   localparam logic [CTR_BITS-1:0] CTR_INIT =
      CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

   logic                valid_q [ENTRIES];
   logic                jump_q  [ENTRIES];
   logic [TAG_W-1:0]    tag_q   [ENTRIES];
   logic [WIDTH-1:0]    tgt_q   [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q   [ENTRIES];

   logic [IDX-1:0]      hist;
   logic                br_upd;

   assign br_upd = update_E && is_branch_E;

   // History lives only in the gshare build; bimodal indexes directly.
   generate
      if (GHR_BITS > 0) begin : g_ghr
         logic [GHR_BITS-1:0] ghr_q;
         always_ff @(posedge clk) begin
            if (rst)
               ghr_q <= '0;
            else if (br_upd)
               ghr_q <= GHR_BITS'({ghr_q, taken_E});
         end
         assign hist = IDX'(ghr_q);
      end else begin : g_bim
         assign hist = '0;
      end
   endgenerate

   logic [IDX-1:0]   idx_f;
   logic [IDX-1:0]   cidx_f;
   logic [TAG_W-1:0] tag_f;
   logic             hit_f;

   assign idx_f  = PC_F[IDX+1:2];
   assign tag_f  = PC_F[WIDTH-1:IDX+2];
   assign cidx_f = idx_f ^ hist;
   assign hit_f  = valid_q[idx_f] && (tag_q[idx_f] == tag_f);

   assign pred_taken_F =
      hit_f && (jump_q[idx_f] || ctr_q[cidx_f][CTR_BITS-1]);
   assign pred_target_F =
      pred_taken_F ? tgt_q[idx_f] : PC_F + WIDTH'(4);

   logic [WIDTH-1:0] seq_e;
   logic [WIDTH-1:0] actual_next;
   logic [WIDTH-1:0] pred_next;

   assign seq_e       = PC_E + WIDTH'(4);
   assign actual_next = taken_E ? target_E : seq_e;
   assign pred_next   = pred_taken_E ? pred_target_E : seq_e;
   assign mispredict_E = update_E && (actual_next != pred_next);
   assign redirect_E   = actual_next;

   logic [IDX-1:0]      idx_e;
   logic [IDX-1:0]      cidx_e;
   logic [TAG_W-1:0]    tag_e;
   logic [CTR_BITS-1:0] ctr_cur;
   logic [CTR_BITS-1:0] ctr_nxt;
   logic                btb_wr;
   logic                alias_clr;

   assign idx_e  = PC_E[IDX+1:2];
   assign tag_e  = PC_E[WIDTH-1:IDX+2];
   assign cidx_e = idx_e ^ hist;

   assign btb_wr = (is_branch_E && taken_E) || is_jump_E;
   // A non-control instruction predicted taken hit a stale entry.
   assign alias_clr = !is_branch_E && !is_jump_E && pred_taken_E &&
                      (tag_q[idx_e] == tag_e);

   always_comb begin
      ctr_cur = ctr_q[cidx_e];
      ctr_nxt = ctr_cur;
      if (taken_E) begin
         if (ctr_cur != CTR_MAX)
            ctr_nxt = ctr_cur + CTR_BITS'(1);
      end else begin
         if (ctr_cur != '0)
            ctr_nxt = ctr_cur - CTR_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            jump_q[i]  <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= CTR_INIT;
         end
      end else if (update_E) begin
         if (is_branch_E)
            ctr_q[cidx_e] <= ctr_nxt;
         unique case (1'b1)
            btb_wr: begin
               valid_q[idx_e] <= 1'b1;
               jump_q[idx_e]  <= is_jump_E;
               tag_q[idx_e]   <= tag_e;
               tgt_q[idx_e]   <= target_E;
            end
            alias_clr: valid_q[idx_e] <= 1'b0;
            default: ;
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = ^{PC_F[1:0], PC_E[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: one bimodal and one gshare predictor on shared inputs.
// Each step drives Execute/Fetch inputs, then checks outputs mid-cycle.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PC_F;
   logic        update_E;
   logic [31:0] PC_E;
   logic        is_branch_E;
   logic        is_jump_E;
   logic        taken_E;
   logic [31:0] target_E;
   logic        pred_taken_E;
   logic [31:0] pred_target_E;

   logic        b_taken, g_taken;
   logic [31:0] b_target, g_target;
   logic        b_mis, g_mis;
   logic [31:0] b_redir, g_redir;

   int passes = 0;
   int total  = 0;

   always #5 clk = ~clk;

   branch_predictor #(.GHR_BITS(0)) u_bim (
      .clk(clk), .rst(rst), .PC_F(PC_F),
      .pred_taken_F(b_taken), .pred_target_F(b_target),
      .update_E(update_E), .PC_E(PC_E),
      .is_branch_E(is_branch_E), .is_jump_E(is_jump_E),
      .taken_E(taken_E), .target_E(target_E),
      .pred_taken_E(pred_taken_E), .pred_target_E(pred_target_E),
      .mispredict_E(b_mis), .redirect_E(b_redir)
   );

   branch_predictor #(.GHR_BITS(2)) u_gsh (
      .clk(clk), .rst(rst), .PC_F(PC_F),
      .pred_taken_F(g_taken), .pred_target_F(g_target),
      .update_E(update_E), .PC_E(PC_E),
      .is_branch_E(is_branch_E), .is_jump_E(is_jump_E),
      .taken_E(taken_E), .target_E(target_E),
      .pred_taken_E(pred_taken_E), .pred_target_E(pred_target_E),
      .mispredict_E(g_mis), .redirect_E(g_redir)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      update_E      = 1'b0;
      PC_E          = 32'h0;
      is_branch_E   = 1'b0;
      is_jump_E     = 1'b0;
      taken_E       = 1'b0;
      target_E      = 32'h0;
      pred_taken_E  = 1'b0;
      pred_target_E = 32'h0;
   endtask

   task automatic res(input logic [31:0] pc, input logic br,
                      input logic jp, input logic tk,
                      input logic [31:0] tgt, input logic ptk,
                      input logic [31:0] ptgt);
      update_E      = 1'b1;
      PC_E          = pc;
      is_branch_E   = br;
      is_jump_E     = jp;
      taken_E       = tk;
      target_E      = tgt;
      pred_taken_E  = ptk;
      pred_target_E = ptgt;
   endtask

   task automatic look(input logic [31:0] pc, input string tag,
                       input logic tk, input logic [31:0] tgt);
      PC_F = pc;
      #1;
      chk({tag, "_taken"}, 32'(b_taken), 32'(tk));
      chk({tag, "_target"}, b_target, tgt);
   endtask

   logic        pt;
   logic [31:0] ptg;
   logic        tk;

   initial begin
      rst  = 1'b1;
      PC_F = 32'h0;
      idle();
      tick();
      for (int i = 0; i < 16; i++) begin
         look(32'(i * 4), "rst_sweep", 1'b0, 32'(i * 4 + 4));
         tick();
      end
      rst = 1'b0;

      // loop branch 0x20 -> 0x10
      res(32'h20, 1, 0, 1, 32'h10, 0, 32'h24);
      #1;
      chk("loop1_mis", 32'(b_mis), 32'd1);
      chk("loop1_redir", b_redir, 32'h10);
      tick();
      idle();
      look(32'h20, "loop_look", 1'b1, 32'h10);
      for (int i = 0; i < 2; i++) begin
         res(32'h20, 1, 0, 1, 32'h10, 1, 32'h10);
         #1;
         chk("loop_carried_mis", 32'(b_mis), 32'd0);
         tick();
      end

      // saturate, then two not-taken
      for (int i = 0; i < 10; i++) begin
         res(32'h20, 1, 0, 1, 32'h10, 1, 32'h10);
         tick();
      end
      res(32'h20, 1, 0, 0, 32'h10, 1, 32'h10);
      #1;
      chk("sat_nt1_mis", 32'(b_mis), 32'd1);
      chk("sat_nt1_redir", b_redir, 32'h24);
      tick();
      idle();
      look(32'h20, "sat_after1", 1'b1, 32'h10);
      res(32'h20, 1, 0, 0, 32'h10, 1, 32'h10);
      tick();
      idle();
      look(32'h20, "sat_after2", 1'b0, 32'h24);

      // JAL 0x04 -> 0x100
      res(32'h04, 0, 1, 1, 32'h100, 0, 32'h08);
      #1;
      chk("jal_mis", 32'(b_mis), 32'd1);
      chk("jal_redir", b_redir, 32'h100);
      tick();
      idle();
      look(32'h04, "jal_look", 1'b1, 32'h100);

      // alias at 0x44, tag differs
      res(32'h44, 0, 0, 0, 32'h0, 1, 32'h100);
      #1;
      chk("alias_mis", 32'(b_mis), 32'd1);
      chk("alias_redir", b_redir, 32'h48);
      tick();
      idle();
      look(32'h04, "alias_keep", 1'b1, 32'h100);
      look(32'h44, "alias_miss", 1'b0, 32'h48);

      // alias with tag match invalidates
      res(32'h04, 0, 0, 0, 32'h0, 1, 32'h100);
      #1;
      chk("alias_tm_redir", b_redir, 32'h08);
      tick();
      idle();
      look(32'h04, "alias_inval", 1'b0, 32'h08);

      // same-cycle collision at index 3
      PC_F = 32'h0C;
      res(32'h0C, 0, 1, 1, 32'h200, 0, 32'h10);
      #1;
      chk("coll_old_taken", 32'(b_taken), 32'd0);
      chk("coll_old_target", b_target, 32'h10);
      tick();
      idle();
      look(32'h0C, "coll_new", 1'b1, 32'h200);
      res(32'h0C, 1, 1, 1, 32'h300, 0, 32'h10);
      update_E = 1'b0;
      #1;
      chk("noupd_mis", 32'(b_mis), 32'd0);
      tick();
      idle();
      look(32'h0C, "noupd_keep", 1'b1, 32'h200);

      // gshare alternating T/N at 0x30
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int it = 0; it < 12; it++) begin
         tk = (it % 2 == 0);
         PC_F = 32'h30;
         #1;
         pt  = g_taken;
         ptg = g_target;
         res(32'h30, 1, 0, tk, 32'h10, pt, ptg);
         #1;
         if (it >= 4)
            chk("gsh_mis", 32'(g_mis), 32'd0);
         tick();
      end
      idle();

      // mid-run reset drops a coincident update
      res(32'h30, 0, 1, 1, 32'h80, 0, 32'h34);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      PC_F = 32'h30;
      #1;
      chk("gsh_rst_taken", 32'(g_taken), 32'd0);
      chk("gsh_rst_target", g_target, 32'h34);
      look(32'h0C, "bim_rst", 1'b0, 32'h10);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
